vga_mem_arbiter: RTL and testbench

Arbitrates one single-port synchronous video RAM between two requesters: the VGA scanout pixel fetch (read, strict priority) and the elevator display updater (write, buffered). Sits between the VGA timing/scanout path and the RAM that holds the floor and status tiles. Scanout reads have fixed latency. Updater writes queue in a small FIFO and drain into idle memory cycles.

---
 rtl/vga_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port synchronous video RAM between the
// VGA scanout reader (strict priority, fixed 2-cycle read latency) and the
// display updater writer (buffered through a small FIFO that drains into
// otherwise idle memory cycles).
//
// Build option: define BLANK_ONLY_WR_EN to restrict queued writes to blanking
// intervals (blank=1) for tear-free updates. Without it, blank is ignored.

module vga_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4,
    localparam int PTR_W   = $clog2(WQ_DEPTH),
    localparam int CNT_W   = $clog2(WQ_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              blank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  wq_count
);

    // Write queue storage and pointers; pointers wrap naturally because
    // WQ_DEPTH is a power of two.
    logic [ADDR_W-1:0] q_addr [WQ_DEPTH];
    logic [DATA_W-1:0] q_data [WQ_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    logic push;
    logic pop;
    logic grant_rd;
    logic grant_wr;
    logic wr_gate;
    logic rd_pipe;

`ifdef BLANK_ONLY_WR_EN
    assign wr_gate = blank;
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign wr_gate      = 1'b1;
`endif

    // Ready comes from the registered count only, so a freshly pushed entry
    // cannot be popped in the same edge (no bypass path).
    assign wr_ready = !reset && (wq_count < CNT_W'(WQ_DEPTH));
    assign push     = wr_valid && wr_ready;
    assign grant_rd = enable && rd_req;
    assign grant_wr = enable && !rd_req && (wq_count != '0) && wr_gate;
    assign pop      = grant_wr;

    // Read data is taken straight from the RAM; rd_valid marks the cycle it
    // belongs to the request made two edges earlier.
    assign rd_data = mem_rdata;

    // Queue payload write; storage needs no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr] <= wr_addr;
            q_data[wptr] <= wr_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            wq_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   wq_count <= wq_count + CNT_W'(1);
                2'b01:   wq_count <= wq_count - CNT_W'(1);
                default: wq_count <= wq_count;
            endcase
        end
    end

    // Registered RAM command: reads win, queued writes fill idle cycles;
    // address and write data hold their last values when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_rd) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
        end else if (grant_wr) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= q_addr[rptr];
            mem_wdata <= q_data[rptr];
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Two-stage read-valid pipeline matching the registered command plus the
    // RAM's one-cycle read latency; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_pipe  <= grant_rd;
            rd_valid <= rd_pipe;
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed vector table for the main read/write/enable
// behaviour, plus hand-written sequences for queue backpressure, reset with
// work in flight, and the blanking-gated write option.

module tb_vga_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        blank;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [2:0]  wq_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]  ram [4096];
    logic [11:0] log_addr [64];
    logic [7:0]  log_data [64];
    int          log_cyc  [64];
    int          log_n = 0;

    vga_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .WQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .blank(blank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wq_count(wq_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous RAM plus a log of every write it receives.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_en && mem_we && log_n < 64) begin
            log_addr[log_n] = mem_addr;
            log_data[log_n] = mem_wdata;
            log_cyc[log_n]  = cyc;
            log_n = log_n + 1;
        end
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        rd;
        logic [11:0] ra;
        logic        wv;
        logic [11:0] wa;
        logic [7:0]  wd;
        logic        e_en;
        logic        e_we;
        logic [11:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_rv;
        logic [7:0]  e_rdata;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int base;
        int idx;
        int guard;
        logic rdy;

        //            en    rd    ra       wv    wa       wd     e_en  e_we  e_addr   e_wdata e_rv  e_rdata e_cnt
        vecs[0]  = '{1'b1, 1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 8'h00, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 12'h011, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h011, 8'h00, 1'b1, 8'h10, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 12'h012, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h012, 8'h00, 1'b1, 8'h11, 3'd0};
        vecs[3]  = '{1'b1, 1'b1, 12'h013, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h013, 8'h00, 1'b1, 8'h12, 3'd0};
        vecs[4]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h013, 8'h00, 1'b1, 8'h13, 3'd0};
        vecs[5]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h013, 8'h00, 1'b0, 8'h00, 3'd0};
        vecs[6]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h100, 8'hA5, 1'b0, 1'b0, 12'h013, 8'h00, 1'b0, 8'h00, 3'd1};
        vecs[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h101, 8'h5A, 1'b1, 1'b1, 12'h100, 8'hA5, 1'b0, 8'h00, 3'd1};
        vecs[8]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 12'h101, 8'h5A, 1'b0, 8'h00, 3'd0};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h101, 8'h5A, 1'b0, 8'h00, 3'd0};
        vecs[10] = '{1'b0, 1'b1, 12'h020, 1'b1, 12'h102, 8'h33, 1'b0, 1'b0, 12'h101, 8'h5A, 1'b0, 8'h00, 3'd1};
        vecs[11] = '{1'b0, 1'b1, 12'h020, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h101, 8'h5A, 1'b0, 8'h00, 3'd1};
        vecs[12] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b1, 12'h102, 8'h33, 1'b0, 8'h00, 3'd0};
        vecs[13] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h102, 8'h33, 1'b0, 8'h00, 3'd0};

        for (int i = 0; i < 4096; i++) ram[i] = i[7:0];

        reset = 1'b1; enable = 1'b1; blank = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        step();
        check("wr_ready_in_reset", 32'(wr_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wq_count", 32'(wq_count), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Table-driven reads, buffered writes, enable gating.
        for (int i = 0; i < 14; i++) begin
            enable = vecs[i].en; rd_req = vecs[i].rd; rd_addr = vecs[i].ra;
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            step();
            check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
            check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rdata));
            check($sformatf("v%0d_wq_count", i), 32'(wq_count), 32'(vecs[i].e_cnt));
        end
        check("ram_100", 32'(ram[12'h100]), 32'h0A5);
        check("ram_101", 32'(ram[12'h101]), 32'h05A);
        check("ram_102", 32'(ram[12'h102]), 32'h033);

        // Reads hold off writes: queue fills, backpressures, then drains in order.
        base = log_n;
        idx = 0;
        enable = 1'b1; rd_req = 1'b1; rd_addr = 12'h200;
        for (int k = 0; k < 8; k++) begin
            wr_valid = (idx < 5);
            wr_addr = 12'h400 + 12'(idx);
            wr_data = 8'hC0 + 8'(idx);
            rdy = wr_ready;
            step();
            if (rdy && wr_valid) idx++;
        end
        check("starve_pushed", 32'(idx), 32'd4);
        check("starve_count", 32'(wq_count), 32'd4);
        check("starve_wr_ready", 32'(wr_ready), 32'd0);
        check("starve_no_write", 32'(log_n - base), 32'd0);
        rd_req = 1'b0;
        guard = 0;
        while (!(idx == 5 && wq_count == 3'd0 && !mem_we) && guard < 30) begin
            wr_valid = (idx < 5);
            wr_addr = 12'h400 + 12'(idx);
            wr_data = 8'hC0 + 8'(idx);
            rdy = wr_ready;
            step();
            if (rdy && wr_valid) idx++;
            guard++;
        end
        wr_valid = 1'b0;
        check("drain_timeout", 32'(guard < 30), 32'd1);
        check("drain_writes", 32'(log_n - base), 32'd5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("drain%0d_addr", j), 32'(log_addr[base + j]), 32'h400 + 32'(j));
            check($sformatf("drain%0d_data", j), 32'(log_data[base + j]), 32'hC0 + 32'(j));
        end
        for (int j = 1; j < 4; j++)
            check($sformatf("drain%0d_consecutive", j), 32'(log_cyc[base + j] - log_cyc[base + j - 1]), 32'd1);

        // Reset with three queued writes and one read in flight.
        enable = 1'b0; rd_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wr_valid = 1'b1; wr_addr = 12'h300 + 12'(j); wr_data = 8'hEE;
            step();
        end
        wr_valid = 1'b0;
        check("pre_reset_count", 32'(wq_count), 32'd3);
        enable = 1'b1; rd_req = 1'b1; rd_addr = 12'h030;
        step();
        check("pre_reset_read", 32'(mem_en), 32'd1);
        base = log_n;
        reset = 1'b1; rd_req = 1'b0;
        step();
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_wq_count", 32'(wq_count), 32'd0);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("post_rst%0d_rd_valid", j), 32'(rd_valid), 32'd0);
        end
        check("post_rst_no_write", 32'(log_n - base), 32'd0);
        check("post_rst_ram_300", 32'(ram[12'h300]), 32'h000);

        // Blank-gated writes.
        base = log_n;
        blank = 1'b0; enable = 1'b1; rd_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 12'h500; wr_data = 8'h11;
        step();
        wr_addr = 12'h501; wr_data = 8'h22;
        step();
        wr_valid = 1'b0;
        for (int j = 0; j < 3; j++) step();
`ifdef BLANK_ONLY_WR_EN
        check("blank_hold_count", 32'(wq_count), 32'd2);
        check("blank_hold_no_write", 32'(log_n - base), 32'd0);
        blank = 1'b1;
        step();
        check("blank_w0_we", 32'(mem_we), 32'd1);
        check("blank_w0_addr", 32'(mem_addr), 32'h500);
        step();
        check("blank_w1_we", 32'(mem_we), 32'd1);
        check("blank_w1_addr", 32'(mem_addr), 32'h501);
        step();
        check("blank_done_we", 32'(mem_we), 32'd0);
        check("blank_done_count", 32'(wq_count), 32'd0);
`else
        check("noblank_count", 32'(wq_count), 32'd0);
        check("noblank_writes", 32'(log_n - base), 32'd2);
        check("noblank_w0_addr", 32'(log_addr[base]), 32'h500);
        check("noblank_w1_addr", 32'(log_addr[base + 1]), 32'h501);
`endif
        step();
        check("ram_500", 32'(ram[12'h500]), 32'h011);
        check("ram_501", 32'(ram[12'h501]), 32'h022);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
